// File: rtl/dsi_pkt_scheduler_if.sv
// dsi_pkt_scheduler_if: host-command and packetizer-request bundle of the DSI packet scheduler.
//  cmd_*  : host DCS short command in (valid held until cmd_ready pulse).
//  pkt_*  : request to the lane packetizer (pkt_req held until pkt_ack).
//  master = scheduler side, slave = host/packetizer side.
interface dsi_pkt_scheduler_if;
  logic        cmd_valid;
  logic [5:0]  cmd_dt;
  logic [15:0] cmd_data;
  logic        cmd_ready;
  logic        pkt_req;
  logic [1:0]  pkt_vc;
  logic [5:0]  pkt_dt;
  logic [15:0] pkt_wc;
  logic        pkt_ack;

  modport master (
    input  cmd_valid, cmd_dt, cmd_data, pkt_ack,
    output cmd_ready, pkt_req, pkt_vc, pkt_dt, pkt_wc
  );

  modport slave (
    output cmd_valid, cmd_dt, cmd_data, pkt_ack,
    input  cmd_ready, pkt_req, pkt_vc, pkt_dt, pkt_wc
  );
endinterface

// File: rtl/dsi_pkt_scheduler.sv
// dsi_pkt_scheduler: turns VSYNC/HSYNC/DE edges into DSI short packets (VSS/VSE/HSS) and one
//  long-packet header request per DE line; slots host short commands into vertical blanking.
// Latency: input edge before E0 -> pending at E1 -> pkt_req high after E2; GAP_CYC gap cycles after ack.
// Backpressure: pkt_req holds until pkt_ack; events keep latching meanwhile and coalesce (ovf_err) if repeated.
// Ports: pixclk, rstn (async active-low); vsync/hsync/de video timing; bus (master modport):
//  cmd_valid/cmd_dt/cmd_data/cmd_ready, pkt_req/pkt_vc/pkt_dt/pkt_wc/pkt_ack;
//  line_cnt (DE lines this frame), frame_cnt (VSS issued), ovf_err (sticky coalesce flag).
// Build option: define DSI_SCHED_VSE_EN to emit VSE (DT 6'h11) on vsync fall.
module dsi_pkt_scheduler #(
  parameter logic [1:0]  VC       = 2'd0,
  parameter logic [5:0]  DT       = 6'h3E,
  parameter logic [15:0] WC       = 16'h05A0,
  parameter logic        SYNC_POL = 1'b1,
  parameter int unsigned GAP_CYC  = 4
) (
  input  logic                       pixclk,
  input  logic                       rstn,
  input  logic                       vsync,
  input  logic                       hsync,
  input  logic                       de,
  dsi_pkt_scheduler_if.master        bus,
  output logic [11:0]                line_cnt,
  output logic [15:0]                frame_cnt,
  output logic                       ovf_err
);

  localparam logic [3:0] GAP_LD = 4'(GAP_CYC - 1);
  localparam logic [5:0] DT_VSS = 6'h01;
  localparam logic [5:0] DT_HSS = 6'h21;
`ifdef DSI_SCHED_VSE_EN
  localparam logic [5:0] DT_VSE = 6'h11;
`endif

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_VSS,
`ifdef DSI_SCHED_VSE_EN
    SEL_VSE,
`endif
    SEL_HSS,
    SEL_LPK,
    SEL_CMD
  } sel_t;

  state_t      state, state_nx;
  sel_t        sel;
  logic [2:0]  sync_in, d1, d2, rise;
  logic        vss_p, hss_p, lpk_p, vblank, ovf_now;
  logic [3:0]  gap_cnt;
  logic [1:0]  pkt_vc_r;
  logic [5:0]  pkt_dt_r;
  logic [15:0] pkt_wc_r;
  logic        cmd_ready_r;

  // Sync inputs normalised to active-high; history bit order {vsync, hsync, de}.
  assign sync_in = {vsync ^ ~SYNC_POL, hsync ^ ~SYNC_POL, de};
  assign rise    = d1 & ~d2;

`ifdef DSI_SCHED_VSE_EN
  logic vse_p, vs_fall;
  assign vs_fall = ~d1[2] & d2[2];
`endif

  // A repeat event is only an overflow if its flag survives this edge (not being issued now).
  always_comb begin
    ovf_now = (rise[2] & vss_p & (sel != SEL_VSS)) |
              (rise[1] & hss_p & (sel != SEL_HSS)) |
              (rise[0] & lpk_p & (sel != SEL_LPK));
`ifdef DSI_SCHED_VSE_EN
    ovf_now = ovf_now | (vs_fall & vse_p & (sel != SEL_VSE));
`endif
  end

  always_ff @(posedge pixclk or negedge rstn) begin
    if (!rstn) begin
      d1      <= '0;
      d2      <= '0;
      vss_p   <= 1'b0;
      hss_p   <= 1'b0;
      lpk_p   <= 1'b0;
      vblank  <= 1'b1;
      ovf_err <= 1'b0;
`ifdef DSI_SCHED_VSE_EN
      vse_p   <= 1'b0;
`endif
    end else begin
      d1      <= sync_in;
      d2      <= d1;
      // New event wins over the clear of the packet being issued this edge.
      vss_p   <= rise[2] | (vss_p & (sel != SEL_VSS));
      hss_p   <= rise[1] | (hss_p & (sel != SEL_HSS));
      lpk_p   <= rise[0] | (lpk_p & (sel != SEL_LPK));
      ovf_err <= ovf_err | ovf_now;
`ifdef DSI_SCHED_VSE_EN
      vse_p   <= vs_fall | (vse_p & (sel != SEL_VSE));
`endif
      if (rise[2])
        vblank <= 1'b1;
      else if (rise[0])
        vblank <= 1'b0;
    end
  end

  always_ff @(posedge pixclk or negedge rstn) begin
    if (!rstn)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Priority VSS > VSE > HSS > LPKT > CMD; CMD only in vblank with nothing else pending.
  always_comb begin
    sel      = SEL_NONE;
    state_nx = state;
    case (state)
      IDLE: begin
        if (vss_p)                        sel = SEL_VSS;
`ifdef DSI_SCHED_VSE_EN
        else if (vse_p)                   sel = SEL_VSE;
`endif
        else if (hss_p)                   sel = SEL_HSS;
        else if (lpk_p)                   sel = SEL_LPK;
        else if (vblank && bus.cmd_valid) sel = SEL_CMD;
        if (sel != SEL_NONE)
          state_nx = REQ;
      end
      REQ:     if (bus.pkt_ack) state_nx = GAP;
      GAP:     if (gap_cnt == 4'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pixclk or negedge rstn) begin
    if (!rstn) begin
      pkt_vc_r    <= '0;
      pkt_dt_r    <= '0;
      pkt_wc_r    <= '0;
      cmd_ready_r <= 1'b0;
      line_cnt    <= '0;
      frame_cnt   <= '0;
      gap_cnt     <= '0;
    end else begin
      cmd_ready_r <= (sel == SEL_CMD);
      if (sel != SEL_NONE)
        pkt_vc_r <= VC;
      case (sel)
        SEL_VSS: begin
          pkt_dt_r  <= DT_VSS;
          pkt_wc_r  <= '0;
          frame_cnt <= frame_cnt + 16'd1;
          line_cnt  <= '0;
        end
`ifdef DSI_SCHED_VSE_EN
        SEL_VSE: begin
          pkt_dt_r <= DT_VSE;
          pkt_wc_r <= '0;
        end
`endif
        SEL_HSS: begin
          pkt_dt_r <= DT_HSS;
          pkt_wc_r <= '0;
        end
        SEL_LPK: begin
          pkt_dt_r <= DT;
          pkt_wc_r <= WC;
          if (line_cnt != 12'hFFF)
            line_cnt <= line_cnt + 12'd1;
        end
        SEL_CMD: begin
          pkt_dt_r <= bus.cmd_dt;
          pkt_wc_r <= bus.cmd_data;
        end
        default: ;
      endcase
      if (state == REQ && bus.pkt_ack)
        gap_cnt <= GAP_LD;
      else if (state == GAP && gap_cnt != 4'd0)
        gap_cnt <= gap_cnt - 4'd1;
    end
  end

  // pkt_req decodes the state directly so reset drops it asynchronously.
  assign bus.pkt_req   = (state == REQ);
  assign bus.pkt_vc    = pkt_vc_r;
  assign bus.pkt_dt    = pkt_dt_r;
  assign bus.pkt_wc    = pkt_wc_r;
  assign bus.cmd_ready = cmd_ready_r;

endmodule

// File: tb/tb_dsi_pkt_scheduler.sv
// tb_dsi_pkt_scheduler: scoreboard bench for dsi_pkt_scheduler.
//  Expected packets are queued as video/command stimulus is driven and popped when the
//  packetizer model acks a request. Counters and flags are checked at quiet points.
module tb_dsi_pkt_scheduler;
  localparam int GAP_CYC  = 4;
  localparam int LINE_LEN = 40;
  localparam int DE_OFS   = 12;
  localparam int DE_LEN   = 16;
`ifdef DSI_SCHED_VSE_EN
  localparam int VSE_EXP = 1;
`else
  localparam int VSE_EXP = 0;
`endif

  logic        pixclk = 1'b0;
  logic        rstn   = 1'b0;
  logic        vsync  = 1'b0;
  logic        hsync  = 1'b0;
  logic        de     = 1'b0;
  logic [11:0] line_cnt;
  logic [15:0] frame_cnt;
  logic        ovf_err;

  dsi_pkt_scheduler_if bus ();

  dsi_pkt_scheduler #(
    .VC(2'd0), .DT(6'h3E), .WC(16'h05A0), .SYNC_POL(1'b1), .GAP_CYC(GAP_CYC)
  ) dut (
    .pixclk    (pixclk),
    .rstn      (rstn),
    .vsync     (vsync),
    .hsync     (hsync),
    .de        (de),
    .bus       (bus.master),
    .line_cnt  (line_cnt),
    .frame_cnt (frame_cnt),
    .ovf_err   (ovf_err)
  );

  always #5 pixclk = ~pixclk;

  typedef struct packed {
    logic [5:0]  dt;
    logic [15:0] wc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   ack_en = 1'b1;
  int   low_cnt = 0, last_gap = 0, n_req = 0;
  int   n_hss = 0, n_lpk = 0, n_vse = 0, n_cmd_rdy = 0;
  int   exp_frames = 0, exp_lines = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic [5:0] dt, input logic [15:0] wc);
    exp_t r;
    r.dt = dt;
    r.wc = wc;
    return r;
  endfunction

  // Packetizer model: ack one cycle after a request is seen, scoring the request then.
  initial begin
    bit   req_prev;
    exp_t e;
    req_prev    = 1'b0;
    bus.pkt_ack = 1'b0;
    forever begin
      @(negedge pixclk);
      if (bus.pkt_req && !req_prev) begin
        last_gap = low_cnt;
        low_cnt  = 0;
        n_req++;
      end
      if (!bus.pkt_req) low_cnt++;
      req_prev = bus.pkt_req;
      if (bus.pkt_ack) begin
        bus.pkt_ack = 1'b0;
      end else if (bus.pkt_req && ack_en) begin
        chk("sb_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("pkt_dt", 32'(bus.pkt_dt), 32'(e.dt));
          chk("pkt_wc", 32'(bus.pkt_wc), 32'(e.wc));
          chk("pkt_vc", 32'(bus.pkt_vc), 32'd0);
        end
        if (bus.pkt_dt == 6'h21) n_hss++;
        if (bus.pkt_dt == 6'h3E) n_lpk++;
        if (bus.pkt_dt == 6'h11) n_vse++;
        bus.pkt_ack = 1'b1;
      end
    end
  end

  // Host side: one cycle step; drops cmd_valid as soon as cmd_ready is seen.
  task automatic tick();
    @(negedge pixclk);
    if (bus.cmd_ready) begin
      n_cmd_rdy++;
      bus.cmd_valid = 1'b0;
    end
  endtask

  // One video line: hsync pulse at start (vsync level changes with it), optional DE run.
  task automatic line(input bit vs, input bit act, input bit with_cmd);
    if (vs && !vsync) begin
      sb.push_back(mk(6'h01, 16'h0000));
      exp_frames++;
      exp_lines = 0;
    end
`ifdef DSI_SCHED_VSE_EN
    if (!vs && vsync) sb.push_back(mk(6'h11, 16'h0000));
`endif
    sb.push_back(mk(6'h21, 16'h0000));
    if (with_cmd) sb.push_back(mk(6'h05, 16'h2900));
    vsync = vs;
    hsync = 1'b1;
    for (int c = 0; c < LINE_LEN; c++) begin
      if (c == 4) hsync = 1'b0;
      if (act && c == DE_OFS) begin
        de = 1'b1;
        sb.push_back(mk(6'h3E, 16'h05A0));
        exp_lines++;
      end
      if (c == DE_OFS + DE_LEN) de = 1'b0;
      tick();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.pkt_req) && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
    repeat (20) tick();
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!bus.pkt_req && n < 50) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(bus.pkt_req), 32'd1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, h0, l0, v0, mark;
    bus.cmd_valid = 1'b0;
    bus.cmd_dt    = 6'h00;
    bus.cmd_data  = 16'h0000;

    // Reset with timing inputs toggling: every output stays 0.
    for (int i = 0; i < 10; i++) begin
      vsync = ~vsync;
      de    = i[1];
      tick();
    end
    chk("rst_req", 32'(bus.pkt_req), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_fields", {8'(bus.pkt_vc), 8'(bus.pkt_dt), bus.pkt_wc}, 32'd0);
    chk("rst_cnts", {4'd0, line_cnt, frame_cnt}, 32'd0);
    chk("rst_ovf", 32'(ovf_err), 32'd0);
    vsync = 1'b0;
    de    = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (20) tick();
    chk("no_req_after_rst", 32'(n_req), 32'd0);

    // vsync and hsync rise together: VSS first, then HSS after the gap.
    sb.push_back(mk(6'h01, 16'h0000));
    sb.push_back(mk(6'h21, 16'h0000));
    exp_frames++;
    vsync = 1'b1;
    hsync = 1'b1;
    lat   = 0;
    while (!bus.pkt_req && lat < 20) begin
      tick();
      lat++;
    end
    // Edges E0 (sample), E1 (pending), E2 (request) -> seen at the third negedge.
    chk("first_req_latency", 32'(lat), 32'd3);
    repeat (3) tick();
    hsync = 1'b0;
    drain();
    // GAP occupies GAP_CYC cycles after the ack edge, plus one IDLE arbitration cycle.
    chk("gap_cycles", 32'(last_gap), 32'(GAP_CYC + 1));
    chk("ovf_after_same_cycle", 32'(ovf_err), 32'd0);
    chk("frame_cnt_t1", 32'(frame_cnt), 32'(exp_frames));

    // Full frame: 830 lines, 800 active.
    line(1'b0, 1'b0, 1'b0);
    line(1'b0, 1'b0, 1'b0);
    drain();
    h0 = n_hss;
    l0 = n_lpk;
    for (int l = 0; l < 830; l++)
      line(l < 3, (l >= 15) && (l < 815), 1'b0);
    drain();
    chk("frame_hss", 32'(n_hss - h0), 32'd830);
    chk("frame_lpkt", 32'(n_lpk - l0), 32'd800);
    chk("line_cnt_eof", 32'(line_cnt), 32'd800);
    chk("ovf_frame", 32'(ovf_err), 32'd0);
    line(1'b1, 1'b0, 1'b0);
    drain();
    chk("frame_cnt_next", 32'(frame_cnt), 32'(exp_frames));
    chk("line_cnt_clr", 32'(line_cnt), 32'd0);

    // Command offered then withdrawn during active video: never taken.
    line(1'b0, 1'b0, 1'b0);
    line(1'b0, 1'b1, 1'b0);
    bus.cmd_dt    = 6'h05;
    bus.cmd_data  = 16'h2900;
    bus.cmd_valid = 1'b1;
    repeat (5) tick();
    bus.cmd_valid = 1'b0;
    line(1'b1, 1'b0, 1'b0);
    drain();
    chk("cmd_dropped_rdy", 32'(n_cmd_rdy), 32'd0);

    // Command held through active video: issued only after the next VSS + HSS.
    line(1'b0, 1'b0, 1'b0);
    line(1'b0, 1'b1, 1'b0);
    bus.cmd_valid = 1'b1;
    line(1'b0, 1'b1, 1'b0);
    line(1'b0, 1'b1, 1'b0);
    drain();
    chk("cmd_held_off", 32'(n_cmd_rdy), 32'd0);
    line(1'b1, 1'b0, 1'b1);
    drain();
    chk("cmd_ready_pulses", 32'(n_cmd_rdy), 32'd1);
    chk("cmd_valid_released", 32'(bus.cmd_valid), 32'd0);

    // vsync fall alone: VSE only when the option is built.
    v0 = n_vse;
    line(1'b0, 1'b0, 1'b0);
    drain();
    chk("vse_on_fall", 32'(n_vse - v0), 32'(VSE_EXP));

    // Ack withheld across two hsync rises: coalesced into one HSS, ovf_err set.
    ack_en = 1'b0;
    vsync  = 1'b1;
    sb.push_back(mk(6'h01, 16'h0000));
    exp_frames++;
    wait_req();
    sb.push_back(mk(6'h21, 16'h0000));
    hsync = 1'b1;
    repeat (4) tick();
    hsync = 1'b0;
    repeat (900) tick();
    chk("ovf_single_pending", 32'(ovf_err), 32'd0);
    hsync = 1'b1;
    repeat (4) tick();
    hsync = 1'b0;
    repeat (1000) tick();
    chk("ovf_coalesce", 32'(ovf_err), 32'd1);
    chk("req_held_dt", {25'd0, bus.pkt_req, bus.pkt_dt}, {25'd0, 1'b1, 6'h01});
    ack_en = 1'b1;
    drain();
    chk("ovf_sticky", 32'(ovf_err), 32'd1);
    chk("frame_cnt_t4", 32'(frame_cnt), 32'(exp_frames));

    // Reset in the middle of a request: request drops at once, pending LPKT is lost.
    line(1'b0, 1'b0, 1'b0);
    drain();
    ack_en = 1'b0;
    hsync  = 1'b1;
    wait_req();
    chk("mid_req_dt", 32'(bus.pkt_dt), 32'h21);
    de = 1'b1;
    repeat (3) tick();
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_req", 32'(bus.pkt_req), 32'd0);
    chk("async_rst_ovf", 32'(ovf_err), 32'd0);
    chk("async_rst_frame", 32'(frame_cnt), 32'd0);
    hsync = 1'b0;
    de    = 1'b0;
    vsync = 1'b0;
    repeat (2) tick();
    rstn   = 1'b1;
    ack_en = 1'b1;
    mark   = n_req;
    repeat (30) tick();
    chk("pending_lost", 32'(n_req - mark), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
